// File: rtl/spi_master_mc.sv
// SPI master with bus register map: CTRL/BAUD/DATA/STATUS, all four CPOL/CPHA modes,
// MSB/LSB-first shifting, one-hot active-low slave selects and a gated DONE interrupt.
module spi_master_mc #(
  parameter int DW  = 8,
  parameter int NSS = 4,
  parameter int SSW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     addr,
  input  logic [15:0]    wdata,
  input  logic           wr,
  input  logic           rd,
  output logic [15:0]    rdata,
  output logic           ack,
  output logic           irq,
  input  logic           SPI_MISO,
  output logic           SPI_MOSI,
  output logic           SPI_SCK,
  output logic [NSS-1:0] SPI_nSS
);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

  localparam logic [5:0] LAST_EDGE = 6'(2 * DW);

  state_t           state, state_nxt;
  logic             en, ien, cpol, cpha, lsbf;
  logic [SSW-1:0]   ssel;
  logic [7:0]       div;
  logic [7:0]       cnt;
  logic [5:0]       ecnt, ecnt_nxt;
  logic [DW-1:0]    tx_sr, rx_sr, rx_word;
  logic             done, ovr;
  logic             mosi_q, sck_q;
  logic [NSS-1:0]   nss_q;

  logic             busy, tick, start, edge_ev, finish;
  logic             drive_ev, sample_ev, sck_nxt;
  logic             wr_ctrl, wr_baud, wr_data, wr_stat, rd_data, rd_en;
  logic [NSS-1:0]   sel_n, nss_nxt;
  logic [15:0]      rd_mux;
  logic             unused_wdata;

  assign unused_wdata = ^wdata;

  function automatic logic first_bit(input logic [DW-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DW-1];
  endfunction

  function automatic logic [DW-1:0] shift_out(input logic [DW-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  assign busy    = (state != IDLE);
  assign rd_en   = rd & ~wr;
  assign wr_ctrl = wr && (addr == 2'd0);
  assign wr_baud = wr && (addr == 2'd1);
  assign wr_data = wr && (addr == 2'd2);
  assign wr_stat = wr && (addr == 2'd3);
  assign rd_data = rd_en && (addr == 2'd2);
  assign tick    = (cnt >= div);
  assign start   = wr_data && en && !busy;

  always_comb begin
    state_nxt = state;
    ecnt_nxt  = ecnt;
    edge_ev   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = LEAD;
      LEAD:  if (tick) begin
               state_nxt = SHIFT;
               ecnt_nxt  = 6'd1;
               edge_ev   = 1'b1;
             end
      SHIFT: if (tick) begin
               if (ecnt == LAST_EDGE) begin
                 state_nxt = TRAIL;
               end else begin
                 ecnt_nxt = ecnt + 6'd1;
                 edge_ev  = 1'b1;
               end
             end
      TRAIL: if (tick) begin
               state_nxt = IDLE;
               finish    = 1'b1;
             end
      default: state_nxt = IDLE;
    endcase
  end

  // Odd edge numbers are leading edges. With CPHA=0 the first bit is preloaded at
  // start, so the final trailing edge does not drive and MOSI holds the last bit.
  always_comb begin
    drive_ev  = 1'b0;
    sample_ev = 1'b0;
    if (edge_ev) begin
      if (cpha) begin
        drive_ev  = ecnt_nxt[0];
        sample_ev = ~ecnt_nxt[0];
      end else begin
        drive_ev  = ~ecnt_nxt[0] && (ecnt_nxt != LAST_EDGE);
        sample_ev = ecnt_nxt[0];
      end
    end
  end

  always_comb begin
    sel_n = '1;
    for (int unsigned i = 0; i < NSS; i++) begin
      if (ssel == SSW'(i)) sel_n[i] = 1'b0;
    end
    nss_nxt = (state_nxt != IDLE) ? sel_n : '1;
    sck_nxt = (state_nxt == SHIFT) ? (cpol ^ ecnt_nxt[0]) : cpol;
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      2'd0: begin
        rd_mux[0]        = en;
        rd_mux[1]        = ien;
        rd_mux[2]        = cpol;
        rd_mux[3]        = cpha;
        rd_mux[4]        = lsbf;
        rd_mux[8 +: SSW] = ssel;
      end
      2'd1:    rd_mux[7:0]    = div;
      2'd2:    rd_mux[DW-1:0] = rx_word;
      default: rd_mux[2:0]    = {ovr, done, busy};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en      <= 1'b0;
      ien     <= 1'b0;
      cpol    <= 1'b0;
      cpha    <= 1'b0;
      lsbf    <= 1'b0;
      ssel    <= '0;
      div     <= '0;
      cnt     <= '0;
      ecnt    <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_word <= '0;
      done    <= 1'b0;
      ovr     <= 1'b0;
      mosi_q  <= 1'b0;
      sck_q   <= 1'b0;
      nss_q   <= '1;
      ack     <= 1'b0;
      rdata   <= '0;
      irq     <= 1'b0;
    end else begin
      ack   <= wr | rd;
      rdata <= rd_en ? rd_mux : '0;
      irq   <= ien & done;
      sck_q <= sck_nxt;
      nss_q <= nss_nxt;
      ecnt  <= ecnt_nxt;

      if (wr_ctrl && !busy) begin
        en   <= wdata[0];
        ien  <= wdata[1];
        cpol <= wdata[2];
        cpha <= wdata[3];
        lsbf <= wdata[4];
        ssel <= wdata[8 +: SSW];
      end
      if (wr_baud) div <= wdata[7:0];

      if (!busy || tick) cnt <= '0;
      else               cnt <= cnt + 8'd1;

      if (start) begin
        if (cpha) begin
          tx_sr <= wdata[DW-1:0];
        end else begin
          mosi_q <= first_bit(wdata[DW-1:0], lsbf);
          tx_sr  <= shift_out(wdata[DW-1:0], lsbf);
        end
      end else if (drive_ev) begin
        mosi_q <= first_bit(tx_sr, lsbf);
        tx_sr  <= shift_out(tx_sr, lsbf);
      end

      if (sample_ev) begin
        if (lsbf) rx_sr <= {SPI_MISO, rx_sr[DW-1:1]};
        else      rx_sr <= {rx_sr[DW-2:0], SPI_MISO};
      end

      if (finish) rx_word <= rx_sr;

      if (finish)       done <= 1'b1;
      else if (rd_data) done <= 1'b0;

      if (wr_data && busy)          ovr <= 1'b1;
      else if (wr_stat && wdata[2]) ovr <= 1'b0;
    end
  end

  assign SPI_MOSI = mosi_q;
  assign SPI_SCK  = sck_q;
  assign SPI_nSS  = nss_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc: register access, mode 0/3 transfers, overrun,
// interrupt timing, mid-transfer reset and slave-select decoding.
module tb_spi_master_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  addr;
  logic [15:0] wdata;
  logic        wr, rd;
  logic [15:0] rdata;
  logic        ack, irq;
  logic        miso, mosi, sck;
  logic [3:0]  nss;
  logic        loopback;
  logic        miso_drv;
  logic [7:0]  slave_pat;

  int n_checks;
  int n_errors;

  always #5 clk = ~clk;

  assign miso = loopback ? mosi : miso_drv;

  spi_master_mc #(.DW(8), .NSS(4), .SSW(3)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wr(wr), .rd(rd),
    .rdata(rdata), .ack(ack), .irq(irq),
    .SPI_MISO(miso), .SPI_MOSI(mosi), .SPI_SCK(sck), .SPI_nSS(nss)
  );

  // Free-running pin monitors; tests take before/after differences.
  int         nss_any_cnt;
  int         nss_bit_cnt [4];
  int         rise_cnt;
  int         fall_cnt;
  int         fall_base;
  logic [7:0] mosi_bits;
  time        rise_t [256];

  always @(posedge clk) begin
    if (nss != 4'hF) nss_any_cnt++;
    for (int i = 0; i < 4; i++) if (!nss[i]) nss_bit_cnt[i]++;
  end

  always @(posedge sck) begin
    rise_t[rise_cnt % 256] = $time;
    mosi_bits = {mosi_bits[6:0], mosi};
    rise_cnt++;
  end

  // Mode-3 slave: presents the next pattern bit on each leading (falling) edge.
  always @(negedge sck) begin
    miso_drv = slave_pat[3'(fall_cnt - fall_base)];
    fall_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    d = rdata;
  endtask

  task automatic wait_idle(input string tag);
    logic [15:0] s;
    int n;
    n = 0;
    do begin
      bus_read(2'd3, s);
      n++;
    end while (s[0] && n < 200);
    check(tag, 32'(s[0]), 32'd0);
  endtask

  logic [15:0] r;
  int b_nss, b_rise, b_bit0, b_bit3;

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
    loopback = 1'b1; slave_pat = 8'h3C;
    repeat (3) @(negedge clk);
    check("rst_nss",   32'(nss),   32'hF);
    check("rst_sck",   32'(sck),   32'd0);
    check("rst_mosi",  32'(mosi),  32'd0);
    check("rst_ack",   32'(ack),   32'd0);
    check("rst_irq",   32'(irq),   32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    rst = 1'b0;
    bus_read(2'd3, r);
    check("rst_status", 32'(r), 32'd0);
    check("ack_rd", 32'(ack), 32'd1);
    bus_read(2'd0, r);
    check("rst_ctrl", 32'(r), 32'd0);

    // wr and rd together: write wins, single ack
    @(negedge clk);
    addr = 2'd1; wdata = 16'h0001; wr = 1'b1; rd = 1'b1;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    check("ack_wrrd",   32'(ack),   32'd1);
    check("rdata_wrrd", 32'(rdata), 32'd0);
    @(negedge clk);
    check("ack_once", 32'(ack), 32'd0);
    bus_read(2'd1, r);
    check("baud_rd", 32'(r), 32'd1);

    // mode 0, MSB first, loopback
    bus_write(2'd0, 16'h0001);
    b_nss = nss_any_cnt; b_rise = rise_cnt; b_bit0 = nss_bit_cnt[0];
    bus_write(2'd2, 16'h00A5);
    wait_idle("m0_busy");
    check("m0_nss_low",  32'(nss_any_cnt - b_nss),      32'd36);
    check("m0_nss0_low", 32'(nss_bit_cnt[0] - b_bit0),  32'd36);
    check("m0_pulses",   32'(rise_cnt - b_rise),        32'd8);
    check("m0_period",   32'(rise_t[(b_rise + 7) % 256] - rise_t[b_rise % 256]), 32'd280);
    check("m0_mosi",     32'(mosi_bits), 32'hA5);
    bus_read(2'd3, r);
    check("m0_done", 32'(r), 32'h2);
    bus_read(2'd2, r);
    check("m0_rx", 32'(r), 32'h00A5);
    bus_read(2'd3, r);
    check("m0_done_clr", 32'(r), 32'h0);

    // mode 3, LSB first, slave drives 0x3C
    bus_write(2'd0, 16'h001D);
    repeat (2) @(negedge clk);
    check("m3_sck_idle", 32'(sck), 32'd1);
    loopback = 1'b0;
    b_rise = rise_cnt; fall_base = fall_cnt;
    bus_write(2'd2, 16'h0081);
    wait_idle("m3_busy");
    check("m3_pulses", 32'(rise_cnt - b_rise), 32'd8);
    check("m3_mosi",   32'(mosi_bits), 32'h81);
    check("m3_sck_end", 32'(sck), 32'd1);
    bus_read(2'd2, r);
    check("m3_rx", 32'(r), 32'h003C);

    // overrun and CTRL write while busy
    bus_write(2'd0, 16'h0001);
    loopback = 1'b1;
    bus_write(2'd2, 16'h003C);
    repeat (4) @(negedge clk);
    bus_write(2'd2, 16'h00FF);
    bus_write(2'd0, 16'h0000);
    bus_read(2'd3, r);
    check("ovr_set", 32'(r), 32'h5);
    wait_idle("ovr_busy");
    check("ovr_mosi", 32'(mosi_bits), 32'h3C);
    bus_read(2'd2, r);
    check("ovr_rx", 32'(r), 32'h003C);
    bus_read(2'd0, r);
    check("ctrl_kept", 32'(r), 32'h0001);
    bus_write(2'd3, 16'h0004);
    bus_read(2'd3, r);
    check("ovr_clr", 32'(r), 32'h0);

    // interrupt: one cycle after DONE, clears one cycle after DATA read
    bus_write(2'd0, 16'h0003);
    bus_write(2'd2, 16'h0055);
    for (int n = 0; n < 100 && nss[0] == 1'b0; n++) @(negedge clk);
    check("irq_nss_rise", 32'(nss), 32'hF);
    check("irq_pre", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_set", 32'(irq), 32'd1);
    bus_read(2'd2, r);
    check("irq_rx", 32'(r), 32'h0055);
    check("irq_hold", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq_clr", 32'(irq), 32'd0);

    // reset mid-shift
    bus_write(2'd2, 16'h00F0);
    repeat (10) @(negedge clk);
    check("mid_nss", 32'(nss), 32'hE);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_nss", 32'(nss), 32'hF);
    check("mid_rst_sck", 32'(sck), 32'd0);
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    bus_read(2'd3, r);
    check("mid_rst_status", 32'(r), 32'h0);

    // DIV=0, SSEL=3
    bus_write(2'd1, 16'h0000);
    bus_write(2'd0, 16'h0301);
    b_nss = nss_any_cnt; b_rise = rise_cnt;
    b_bit0 = nss_bit_cnt[0]; b_bit3 = nss_bit_cnt[3];
    bus_write(2'd2, 16'h00C3);
    wait_idle("s3_busy");
    check("s3_nss_low",  32'(nss_any_cnt - b_nss),     32'd18);
    check("s3_nss3_low", 32'(nss_bit_cnt[3] - b_bit3), 32'd18);
    check("s3_nss0_low", 32'(nss_bit_cnt[0] - b_bit0), 32'd0);
    check("s3_pulses",   32'(rise_cnt - b_rise),       32'd8);
    check("s3_period",   32'(rise_t[(b_rise + 7) % 256] - rise_t[b_rise % 256]), 32'd140);
    bus_read(2'd2, r);
    check("s3_rx", 32'(r), 32'h00C3);

    // SSEL=5 selects nothing but still completes
    bus_write(2'd0, 16'h0501);
    b_nss = nss_any_cnt; b_rise = rise_cnt;
    bus_write(2'd2, 16'h005A);
    wait_idle("s5_busy");
    check("s5_nss_low", 32'(nss_any_cnt - b_nss), 32'd0);
    check("s5_pulses",  32'(rise_cnt - b_rise),   32'd8);
    bus_read(2'd3, r);
    check("s5_done", 32'(r), 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_master_mc.md
Name: spi_master_mc

Overview:
- Parametrised successor to the single-mode SPI interface: SPI master with configurable word width, all four CPOL/CPHA modes, MSB/LSB-first and NSS one-hot slave selects.
- Sits between the internal bus decoder (wr/rd/ack strobes) and the SPI pins.
- Adds a 4-register map, a sticky status/overrun flag and a gated interrupt.

Parameters:
- DW, 8, data word width in bits, legal 4..16.
- NSS, 4, number of slave-select outputs, legal 1..8.
- SSW, 3, width of slave index field; must satisfy 2^SSW >= NSS.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- addr  in  2  register select: 0 CTRL, 1 BAUD, 2 DATA, 3 STATUS
- wdata  in  16  write data
- wr  in  1  write strobe, one cycle
- rd  in  1  read strobe, one cycle
- rdata  out  16  read data, valid while ack=1, else 0
- ack  out  1  one-cycle acknowledge
- irq  out  1  interrupt request, level
- SPI_MISO  in  1  master-in-slave-out
- SPI_MOSI  out  1  master-out-slave-in
- SPI_SCK  out  1  serial clock
- SPI_nSS  out  NSS  active-low slave selects, at most one low

Behaviour:
- Reset: all registers 0, FSM IDLE, rdata=0, ack=0, irq=0, SPI_SCK=0, SPI_MOSI=0, SPI_nSS all 1.
- Reset mid-transfer aborts the transfer immediately (next edge), with no DONE.
- CTRL register:
  - bit0 EN, bit1 IEN, bit2 CPOL, bit3 CPHA, bit4 LSBF, bits[8+:SSW] SSEL.
  - Writes to CTRL while BUSY are ignored but acked.
- BAUD register: [7:0] DIV. SCK half-period = DIV+1 clk cycles; DIV=0 gives SCK=clk/2.
- DATA register:
  - A write with EN=1 and BUSY=0 loads the tx shifter and starts a transfer.
  - A write with BUSY=1 sets OVR and changes nothing else.
  - A write with EN=0 is ignored.
  - A read returns the rx word zero-extended and clears DONE.
- STATUS register:
  - bit0 BUSY, bit1 DONE, bit2 OVR.
  - Writing with wdata[2]=1 clears OVR. Other bits are read-only.
- Bus handshake:
  - ack = 1 exactly one cycle after wr or rd is sampled, with rdata valid the same cycle.
  - If wr and rd are both high, the write is performed and only one ack is issued.
- SCK idle level = CPOL whenever the FSM is not in SHIFT.
- FSM states: IDLE -> LEAD -> SHIFT -> TRAIL -> IDLE.
  - IDLE: on a start, BUSY=1 and nSS[SSEL] drops the next cycle. An SSEL >= NSS asserts no select, but the transfer still runs.
  - LEAD: lasts one half-period. For CPHA=0 the first bit is on MOSI throughout LEAD.
  - SHIFT: 2*DW SCK edges, one per half-period.
    - CPHA=0: sample MISO on odd (leading) edges, drive the next bit on even edges.
    - CPHA=1: drive on leading edges, sample on trailing edges.
  - TRAIL: lasts one half-period with SCK=CPOL. At the end, nSS goes high, BUSY=0, DONE=1 and the rx word is latched, all in the same cycle.
- Bit order: LSBF=0 sends MSB first; LSBF=1 sends bit 0 first. Received bits are assembled in the same order.
- Total transfer time: (2*DW+2)*(DIV+1) cycles, from nSS low to BUSY low.
- irq is registered: irq = IEN & DONE, one cycle after either term changes.
- Simultaneous events:
  - A DATA read in the same cycle that DONE sets leaves DONE=1, because set wins.
  - A DATA write in the cycle BUSY falls is treated as busy, so OVR is set.

Test Plan:
- DW=8, DIV=1, CTRL=EN, mode 0, SSEL=0, MISO looped to MOSI, write DATA=0xA5 -> nSS[0] low for 36 clk, 8 SCK pulses of period 4 clk, MOSI bits 1,0,1,0,0,1,0,1, DATA read = 0x00A5, DONE then 0.
- Mode 3 (CPOL=1, CPHA=1), LSBF=1, MISO driven with pattern 0x3C LSB-first, tx 0x81 -> SCK idles high, MOSI bits 1,0,0,0,0,0,0,1, rx = 0x3C.
- Write DATA during transfer -> OVR=1, original word completes unchanged. Then write STATUS=0x4 -> OVR=0.
- IEN=1, complete a transfer -> irq=1 one cycle after DONE. Read DATA -> irq=0 on the following cycle.
- Assert rst mid-SHIFT -> next cycle all nSS=1, SCK=CPOL reset value 0, BUSY=0, DONE=0, ack=0.
- DIV=0, SSEL=3, NSS=4 -> only nSS[3] low, SCK toggles every clk, 18-cycle transfer. With SSEL=5, no nSS goes low and DONE still sets.
